// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings,
// the default operand width and the bit-counter width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;

    // One spare bit so the counter can represent WIDTH itself without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the per-bit datapath of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic c_out,
    output logic s
);

    assign s     = a ^ b ^ c;
    assign c_out = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one operand bit per cycle through a single full adder,
// LSB first, with a registered {cout, sum, ovf} result and a one-cycle done pulse.
//
// Handshake: start is sampled only in IDLE. busy rises on the accepted start
// edge and stays high through RUN and DONE. done is high for exactly the one
// DONE cycle, when sum/cout/ovf are valid; they then hold until the next
// accepted start. start seen while busy is ignored.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_c;
    logic             fa_s;

    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .c_out (fa_c),
        .s     (fa_s)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB position.
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): drivers push hand-computed
// results into exp_q, a negedge monitor pops and compares on every done.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [1:0]       state_dbg;

    logic [WIDTH+1:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // scoreboard monitor
    initial begin
        logic [WIDTH+1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_sum",  32'(sum),  32'(e[WIDTH-1:0]));
                    check("result_cout", 32'(cout), 32'(e[WIDTH+1]));
                    check("result_ovf",  32'(ovf),  32'(e[WIDTH]));
                end
            end
        end
    end

    // Called right after a negedge. mode 1: re-drive operands/start mid-RUN.
    // mode 2: assert start during the DONE cycle and check it is ignored.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input int mode);
        int n;
        int busy_hi;
        bit seen;
        a = av; b = bv; cin = cv; start = 1'b1;
        exp_q.push_back({ec, eo, es});
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                check("busy_after_start", 32'(busy), 32'd1);
            end
            if (mode == 1 && n == 3) begin
                a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
            end
            if (mode == 1 && n == 5) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check("done_latency", 32'(n), 32'(WIDTH + 1));
        if (mode == 2) begin
            a = 8'h33; b = 8'h44; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("idle_after_done", 32'(state_dbg), 32'd0);
        check("sum_hold", 32'(sum), 32'(es));
        if (mode == 2) begin
            busy_hi = 0;
            repeat (12) begin
                @(negedge clk);
                if (busy) busy_hi++;
            end
            check("start_in_done_ignored", 32'(busy_hi), 32'd0);
            check("sum_hold_long", 32'(sum), 32'(es));
            check("cout_hold_long", 32'(cout), 32'(ec));
        end
    endtask

    // stimulus
    initial begin
        int t;
        int last;
        int k;
        int busy_low;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sum",   32'(sum),       32'd0);
        check("rst_cout",  32'(cout),      32'd0);
        check("rst_ovf",   32'(ovf),       32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;

        // start on the first edge after reset release
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        do_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1);
        do_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        do_op(8'hC0, 8'h80, 1'b0, 8'h40, 1'b1, 1'b1, 0);
        do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 2);
        do_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);

        // reset at the 4th RUN edge aborts without a done pulse
        a = 8'h5A; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_sum",   32'(sum),       32'd0);
        check("abort_busy",  32'(busy),      32'd0);
        check("abort_done",  32'(done),      32'd0);
        check("abort_cout",  32'(cout),      32'd0);
        check("abort_ovf",   32'(ovf),       32'd0);
        check("abort_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0, 0);

        // start held high: back-to-back operations every 10 cycles
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back({1'b0, 1'b0, 8'h02});
        t = 0; last = 0; k = 0; busy_low = 0;
        while (k < 3 && t < 60) begin
            @(negedge clk);
            t++;
            if (k > 0 && !busy) busy_low++;
            if (done) begin
                if (k > 0) check("held_period", 32'(t - last), 32'd10);
                last = t;
                k++;
                if (k == 3) start = 1'b0;
            end
        end
        check("held_done_count", 32'(k), 32'd3);
        check("held_busy_gap", 32'(busy_low), 32'd2);
        repeat (3) @(negedge clk);
        check("held_back_idle", 32'(state_dbg), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1: request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH: operand A, captured on the accepted start edge.
REQ-006 SHALL have port b, input, WIDTH: operand B, captured on the accepted start edge.
REQ-007 SHALL have port cin, input, 1: carry-in, captured on the accepted start edge.
REQ-008 SHALL have port busy, output, 1: high in RUN and DONE.
REQ-009 SHALL have port done, output, 1: single-cycle pulse; result valid.
REQ-010 SHALL have port sum, output, WIDTH: registered result.
REQ-011 SHALL have port cout, output, 1: carry out of the MSB.
REQ-012 SHALL have port ovf, output, 1: signed overflow, defined as the carry into the MSB XOR cout.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL make these transitions: IDLE->RUN on start=1; RUN->DONE after WIDTH bit-cycles; DONE->IDLE unconditionally.
REQ-015 SHALL, on an accepted start, load shift registers with a and b, load the carry register with cin, and clear the bit counter.
REQ-016 SHALL, on each RUN edge, add the A LSB, the B LSB and the carry register through one 1-bit full adder.
REQ-017 SHALL, on each RUN edge, shift the sum bit into the sum register MSB-first (right shift), store the new carry, shift A and B right, and increment the counter.
REQ-018 SHALL hold the carry into the MSB from the final bit-cycle for the ovf computation.
REQ-019 SHALL use a counter width of clog2(WIDTH)+1 bits; the counter SHALL NOT wrap during RUN, and the transition to DONE SHALL occur when count reaches WIDTH-1 on a RUN edge.
REQ-020 SHALL set latency so that done is high exactly during the cycle following the (WIDTH+1)th rising edge after the start-sampling edge (WIDTH=8: 9 edges).
REQ-021 SHALL drive done high for exactly one cycle per accepted start.
REQ-022 SHALL keep sum, cout and ovf stable from DONE until the next accepted start.
REQ-023 SHALL ignore start while busy=1, including start asserted in the DONE cycle; no capture and no state change.
REQ-024 SHALL NOT disturb an operation in progress when a, b or cin change during RUN.
REQ-025 SHALL produce a result equal to {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0 and shift registers to 0.
REQ-027 SHALL abort any operation in progress on reset, with no done pulse issued for it.
REQ-028 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the state encodings (IDLE=0, RUN=1, DONE=2, 2-bit) and the default WIDTH constant in a shared package serial_add_pkg.
REQ-030 SHALL instantiate exactly one sub-module, full_adder (inputs a, b, c; outputs c_out, s), as the per-bit datapath.
REQ-031 SHALL keep all other logic in the controller.

Verification
REQ-032 SHALL cover: WIDTH=8, a=0xFF, b=0x01, cin=0, start pulse -> done on the 9th edge; sum=0x00, cout=1, ovf=0.
REQ-033 SHALL cover: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; and a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-034 SHALL cover: a=0x12, b=0x34, cin=1 -> sum=0x47, cout=0; new a/b driven and start re-pulsed mid-RUN -> result unchanged (0x47), exactly one done pulse.
REQ-035 SHALL cover: rst_n pulsed low at the 4th RUN edge -> all outputs 0 immediately, no done pulse; fresh start on the first post-reset edge completes normally.
REQ-036 SHALL cover: start held high continuously with a=0x01, b=0x01 -> one done every 10 cycles, sum=0x02 each time, busy low for exactly 1 cycle between operations.
